// File: rtl/coreport_wbm_if.sv
// Wishbone classic bus bundle used between coreport_wbm (master) and a responder (slave).
interface coreport_wbm_if #(
  parameter int unsigned WIDTH = 8
);
  logic [31:0]      wb_adr_o;
  logic [WIDTH-1:0] wb_dat_o;
  logic             wb_we_o;
  logic             wb_cyc_o;
  logic             wb_stb_o;
  logic [2:0]       wb_cti_o;
  logic [1:0]       wb_bte_o;
  logic [WIDTH-1:0] wb_dat_i;
  logic             wb_ack_i;
  logic             wb_err_i;
  logic             wb_rty_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );
endinterface

// File: rtl/coreport_wbm.sv
// Single-outstanding Wishbone classic initiator: one command -> one bus cycle -> one response.
// Optional bus timeout enabled by defining COREPORT_WBM_TIMEOUT_EN.
module coreport_wbm #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned RD_DATA_DELAY  = 1,
  parameter int unsigned MAX_RETRY      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [31:0]      cmd_adr_i,
  input  logic [WIDTH-1:0] cmd_dat_i,
  input  logic             cmd_we_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_dat_o,
  output logic [1:0]       rsp_status_o,
  output logic             busy_o,
  coreport_wbm_if.master   wb
);

  typedef enum logic [2:0] {StIdle, StBus, StRdWait, StRetry, StRsp} state_e;

  localparam logic [1:0] StatOk  = 2'b00;
  localparam logic [1:0] StatErr = 2'b01;
  localparam logic [1:0] StatRty = 2'b10;
  localparam logic [1:0] StatTmo = 2'b11;
  localparam logic [1:0] RdDly   = 2'(RD_DATA_DELAY);
  localparam logic [3:0] MaxRty  = 4'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [31:0]      adr_q, adr_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             we_q, we_d;
  logic             cyc_q, cyc_d;
  logic [3:0]       retry_q, retry_d;
  logic [1:0]       dly_q, dly_d;
  logic [WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic [1:0]       rsp_status_q, rsp_status_d;
  logic             tmo_hit;

`ifdef COREPORT_WBM_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [TmoW-1:0] tmo_q, tmo_d;

  // Counts only cycles with cyc/stb driven, so every (re)entry to BUS restarts it.
  always_comb begin
    tmo_d = '0;
    if (state_q == StBus && cyc_q) tmo_d = tmo_q + 1'b1;
  end

  assign tmo_hit = (state_q == StBus) && cyc_q && (tmo_q == TmoLast);

  always_ff @(posedge wb_clk) begin
    if (wb_rst) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign cmd_ready_o  = (state_q == StIdle) && !wb_rst;
  assign rsp_valid_o  = (state_q == StRsp);
  assign busy_o       = (state_q != StIdle);
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;

  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_cti_o = 3'b000;
  assign wb.wb_bte_o = 2'b00;

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    we_d         = we_q;
    cyc_d        = cyc_q;
    retry_d      = retry_q;
    dly_d        = dly_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i && cmd_ready_o) begin
          adr_d     = cmd_adr_i;
          dat_d     = cmd_dat_i;
          we_d      = cmd_we_i;
          retry_d   = '0;
          rsp_dat_d = '0;
          state_d   = StBus;
        end
      end
      StBus: begin
        // First BUS cycle after accept only launches cyc/stb; responses are sampled afterwards.
        if (!cyc_q) begin
          cyc_d = 1'b1;
        end else if (wb.wb_err_i) begin
          cyc_d        = 1'b0;
          rsp_status_d = StatErr;
          state_d      = StRsp;
        end else if (wb.wb_ack_i) begin
          cyc_d = 1'b0;
          if (we_q) begin
            rsp_status_d = StatOk;
            state_d      = StRsp;
          end else if (RD_DATA_DELAY == 0) begin
            rsp_dat_d    = wb.wb_dat_i;
            rsp_status_d = StatOk;
            state_d      = StRsp;
          end else begin
            dly_d   = 2'd1;
            state_d = StRdWait;
          end
        end else if (wb.wb_rty_i) begin
          cyc_d = 1'b0;
          if (retry_q == MaxRty) begin
            rsp_status_d = StatRty;
            state_d      = StRsp;
          end else begin
            retry_d = retry_q + 4'd1;
            state_d = StRetry;
          end
        end else if (tmo_hit) begin
          cyc_d        = 1'b0;
          rsp_status_d = StatTmo;
          state_d      = StRsp;
        end
      end
      StRdWait: begin
        if (dly_q == RdDly) begin
          rsp_dat_d    = wb.wb_dat_i;
          rsp_status_d = StatOk;
          state_d      = StRsp;
        end else begin
          dly_d = dly_q + 2'd1;
        end
      end
      StRetry: begin
        cyc_d   = 1'b1;
        state_d = StBus;
      end
      StRsp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q      <= StIdle;
      adr_q        <= '0;
      dat_q        <= '0;
      we_q         <= 1'b0;
      cyc_q        <= 1'b0;
      retry_q      <= '0;
      dly_q        <= '0;
      rsp_dat_q    <= '0;
      rsp_status_q <= StatOk;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      we_q         <= we_d;
      cyc_q        <= cyc_d;
      retry_q      <= retry_d;
      dly_q        <= dly_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
    end
  end

endmodule

// File: tb/tb_coreport_wbm.sv
// Directed bench for coreport_wbm with a GPIO-style responder and a response scoreboard.
module tb_coreport_wbm;

  localparam logic [1:0] StOk  = 2'b00;
  localparam logic [1:0] StErr = 2'b01;
  localparam logic [1:0] StRty = 2'b10;
  localparam logic [1:0] StTmo = 2'b11;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [31:0] cmd_adr_i = '0;
  logic [7:0]  cmd_dat_i = '0;
  logic        cmd_we_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [7:0]  rsp_dat_o;
  logic [1:0]  rsp_status_o;
  logic        busy_o;

  coreport_wbm_if #(.WIDTH(8)) bus ();

  coreport_wbm #(
    .WIDTH          (8),
    .RD_DATA_DELAY  (1),
    .MAX_RETRY      (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .wb_clk       (wb_clk),
    .wb_rst       (wb_rst),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_adr_i    (cmd_adr_i),
    .cmd_dat_i    (cmd_dat_i),
    .cmd_we_i     (cmd_we_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_dat_o    (rsp_dat_o),
    .rsp_status_o (rsp_status_o),
    .busy_o       (busy_o),
    .wb           (bus)
  );

  always #5 wb_clk = ~wb_clk;

  // Responder: 0 GPIO (ack=stb), 1 err+ack, 2 always rty, 3 rty twice then ack, 4 silent.
  int         mode = 0;
  logic [7:0] mem [0:255];
  logic [7:0] rd_q = '0;
  logic       mon_clr = 1'b1;
  logic       stb_prev = 1'b0;
  int         pulses = 0, hi_cycles = 0, bad_gap = 0, low_run = 0, rty_seen = 0;

  always_comb begin
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_rty_i = 1'b0;
    bus.wb_dat_i = rd_q;
    if (bus.wb_cyc_o && bus.wb_stb_o) begin
      case (mode)
        0: bus.wb_ack_i = 1'b1;
        1: begin bus.wb_ack_i = 1'b1; bus.wb_err_i = 1'b1; end
        2: bus.wb_rty_i = 1'b1;
        3: if (rty_seen < 2) bus.wb_rty_i = 1'b1; else bus.wb_ack_i = 1'b1;
        default: ;
      endcase
    end
  end

  always @(posedge wb_clk) begin
    if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i) begin
      if (bus.wb_we_o) mem[bus.wb_adr_o[7:0]] <= bus.wb_dat_o;
      else             rd_q <= mem[bus.wb_adr_o[7:0]];
    end
  end

  always @(posedge wb_clk) begin
    stb_prev <= bus.wb_stb_o;
    if (mon_clr) begin
      pulses <= 0; hi_cycles <= 0; bad_gap <= 0; low_run <= 0; rty_seen <= 0;
    end else begin
      if (bus.wb_stb_o) hi_cycles <= hi_cycles + 1;
      else              low_run <= low_run + 1;
      if (bus.wb_stb_o && !stb_prev) begin
        if (pulses != 0 && low_run != 1) bad_gap <= bad_gap + 1;
        pulses  <= pulses + 1;
        low_run <= 0;
      end
      if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_rty_i) rty_seen <= rty_seen + 1;
    end
  end

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] dat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge wb_clk);
    mon_clr = 1'b0;
  endtask

  // Called at a negedge; returns at the first negedge after the accepting edge.
  task automatic issue(input logic [31:0] adr, input logic [7:0] dat, input logic we);
    logic ok;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_we_i    = we;
    cmd_valid_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready_o) begin ok = 1'b1; break; end
      @(negedge wb_clk);
    end
    check("cmd accepted", ok, 1);
    @(posedge wb_clk);
    @(negedge wb_clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic collect(input string tag, input int max_cyc, output int lat);
    exp_t e;
    lat = 0;
    while (!rsp_valid_o && lat < max_cyc) begin
      @(negedge wb_clk);
      lat++;
    end
    check({tag, " rsp_valid"}, rsp_valid_o, 1);
    check({tag, " scoreboard has entry"}, sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " status"}, rsp_status_o, e.st);
      check({tag, " rsp_dat"}, rsp_dat_o, e.dat);
    end
    rsp_ready_i = 1'b1;
    @(negedge wb_clk);
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    int   lat;
    logic ok;
    exp_t e;

    // Reset state
    repeat (2) @(negedge wb_clk);
    check("rst cmd_ready", cmd_ready_o, 0);
    check("rst rsp_valid", rsp_valid_o, 0);
    check("rst cyc", bus.wb_cyc_o, 0);
    check("rst stb", bus.wb_stb_o, 0);
    check("rst we", bus.wb_we_o, 0);
    check("rst busy", busy_o, 0);
    check("rst rsp_dat", rsp_dat_o, 0);
    check("rst status", rsp_status_o, 0);
    check("rst adr", bus.wb_adr_o, 0);
    check("rst dat_o", bus.wb_dat_o, 0);
    wb_rst = 1'b0;
    @(negedge wb_clk);
    check("idle cmd_ready", cmd_ready_o, 1);
    mon_clr = 1'b0;

    // GPIO write then read
    sb.push_back('{st: StOk, dat: 8'h00});
    issue(32'h14, 8'hA5, 1'b1);
    check("wr cti", bus.wb_cti_o, 0);
    check("wr bte", bus.wb_bte_o, 0);
    collect("gpio wr", 10, lat);
    check("gpio wr latency", lat, 2);
    sb.push_back('{st: StOk, dat: 8'hA5});
    issue(32'h14, 8'h00, 1'b0);
    collect("gpio rd", 10, lat);
    check("gpio rd latency", lat, 3);

    // Back-to-back with response stalled
    clear_mon();
    sb.push_back('{st: StOk, dat: 8'h00});
    sb.push_back('{st: StOk, dat: 8'h3C});
    issue(32'h20, 8'h3C, 1'b1);
    cmd_adr_i = 32'h20; cmd_we_i = 1'b0; cmd_dat_i = 8'h00; cmd_valid_i = 1'b1;
    for (int i = 0; i < 10 && !rsp_valid_o; i++) @(negedge wb_clk);
    for (int i = 0; i < 5; i++) begin
      check("stall cmd_ready", cmd_ready_o, 0);
      check("stall rsp_valid", rsp_valid_o, 1);
      check("stall rsp_dat", rsp_dat_o, 8'h00);
      check("stall status", rsp_status_o, StOk);
      @(negedge wb_clk);
    end
    check("stall single bus cycle", pulses, 1);
    e = sb.pop_front();
    check("b2b wr status", rsp_status_o, e.st);
    check("b2b wr rsp_dat", rsp_dat_o, e.dat);
    rsp_ready_i = 1'b1;
    @(negedge wb_clk);
    rsp_ready_i = 1'b0;
    check("b2b 2nd accepted", cmd_ready_o, 1);
    @(posedge wb_clk);
    @(negedge wb_clk);
    cmd_valid_i = 1'b0;
    collect("b2b rd", 10, lat);
    check("b2b pulses", pulses, 2);

    // err together with ack on a read
    mode = 1;
    clear_mon();
    sb.push_back('{st: StErr, dat: 8'h00});
    issue(32'h14, 8'h00, 1'b0);
    collect("err rd", 10, lat);
    check("err pulses", pulses, 1);

    // Retry exhausted
    mode = 2;
    clear_mon();
    sb.push_back('{st: StRty, dat: 8'h00});
    issue(32'h30, 8'h00, 1'b0);
    collect("rty exh", 30, lat);
    check("rty exh pulses", pulses, 3);
    check("rty exh stb cycles", hi_cycles, 3);
    check("rty exh gaps", bad_gap, 0);

    // Retry twice then ack
    mode = 3;
    clear_mon();
    sb.push_back('{st: StOk, dat: 8'h00});
    issue(32'h31, 8'h77, 1'b1);
    collect("rty ok", 30, lat);
    check("rty ok pulses", pulses, 3);
    check("rty ok gaps", bad_gap, 0);

    // Silent responder
    mode = 4;
    clear_mon();
`ifdef COREPORT_WBM_TIMEOUT_EN
    sb.push_back('{st: StTmo, dat: 8'h00});
    issue(32'h40, 8'h00, 1'b0);
    collect("timeout", 40, lat);
    check("timeout stb cycles", hi_cycles, 16);
    check("timeout pulses", pulses, 1);
`else
    issue(32'h40, 8'h00, 1'b0);
    @(negedge wb_clk);
    ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (!(bus.wb_cyc_o && bus.wb_stb_o) || rsp_valid_o) ok = 1'b0;
      @(negedge wb_clk);
    end
    check("no timeout cyc held", ok, 1);
    wb_rst = 1'b1;
    @(negedge wb_clk);
    wb_rst = 1'b0;
    @(negedge wb_clk);
    check("no timeout recover busy", busy_o, 0);
`endif

    // Reset in the middle of a write
    issue(32'h50, 8'h11, 1'b1);
    @(negedge wb_clk);
    check("pre-rst cyc", bus.wb_cyc_o, 1);
    wb_rst = 1'b1;
    @(negedge wb_clk);
    check("mid-rst cyc", bus.wb_cyc_o, 0);
    check("mid-rst stb", bus.wb_stb_o, 0);
    check("mid-rst rsp_valid", rsp_valid_o, 0);
    check("mid-rst cmd_ready", cmd_ready_o, 0);
    wb_rst = 1'b0;
    @(negedge wb_clk);
    check("post-rst cmd_ready", cmd_ready_o, 1);
    check("post-rst rsp_valid", rsp_valid_o, 0);
    check("post-rst busy", busy_o, 0);
    mode = 0;
    sb.push_back('{st: StOk, dat: 8'hA5});
    issue(32'h14, 8'h00, 1'b0);
    collect("post-rst rd", 10, lat);
    check("post-rst rd latency", lat, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/coreport_wbm.md
Name: coreport_wbm

Overview:
- Single-outstanding Wishbone classic initiator: turns a command handshake into one bus cycle and returns a response.
- Its primary target is the team's Wishbone GPIO port, which has combinational ack and registered read data. It works with any classic responder.
- Sits between a CPU-less controller (sequencer, debug bridge, UART command decoder) and the peripheral bus.

Parameters:
- WIDTH, 8, data path width for cmd_dat_i, wb_dat_o, wb_dat_i, rsp_dat_o.
- RD_DATA_DELAY, 1, edges after the ack edge at which wb_dat_i is captured (0..3). Use 1 for registered-read-data responders.
- MAX_RETRY, 2, number of reissues after rty before giving up (0..15).
- TIMEOUT_CYCLES, 256, cycles in BUS without ack/err/rty before abort (>=2). Used only with the optional feature.

Ports:
- wb_clk  in  1  clock.
- wb_rst  in  1  synchronous active-high reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_adr_i  in  32  target address.
- cmd_dat_i  in  WIDTH  write data.
- cmd_we_i  in  1  1=write, 0=read.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_dat_o  out  WIDTH  read data (0 for writes).
- rsp_status_o  out  2  00 OK, 01 ERR, 10 RTY exhausted, 11 TIMEOUT.
- busy_o  out  1  high in any state other than IDLE.
- wb_adr_o  out  32  bus address.
- wb_dat_o  out  WIDTH  bus write data.
- wb_we_o  out  1  bus write enable.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  bus strobe.
- wb_cti_o  out  3  constant 3'b000 (classic).
- wb_bte_o  out  2  constant 2'b00.
- wb_dat_i  in  WIDTH  bus read data.
- wb_ack_i  in  1  bus acknowledge.
- wb_err_i  in  1  bus error.
- wb_rty_i  in  1  bus retry.

Behaviour:
- Reset values: cmd_ready_o=0 during reset and 1 in IDLE afterwards.
- Reset values: rsp_valid_o, wb_cyc_o, wb_stb_o, wb_we_o, busy_o = 0.
- Reset values: rsp_dat_o, rsp_status_o, wb_adr_o, wb_dat_o = 0.
- States: IDLE, BUS, RDWAIT, RETRY, RSP.
- IDLE:
  - cmd_ready_o=1.
  - On the edge with cmd_valid_i & cmd_ready_o, latch adr/dat/we into the wb_* outputs, clear the retry count, and go to BUS.
  - cyc/stb are high from the next cycle.
- BUS:
  - cyc=stb=1; adr/dat/we held stable for the whole transaction, including retries.
  - Responses are sampled at each edge. Priority: err > ack > rty.
  - err: drop cyc/stb, status 01, go to RSP.
  - ack, write: drop cyc/stb, status 00, go to RSP.
  - ack, read, RD_DATA_DELAY=0: capture wb_dat_i at this edge, then RSP.
  - ack, read, RD_DATA_DELAY>0: go to RDWAIT.
  - rty with count<MAX_RETRY: increment count, go to RETRY.
  - rty with count=MAX_RETRY: status 10, go to RSP.
- RDWAIT:
  - cyc/stb=0.
  - Count RD_DATA_DELAY edges from the ack edge; capture wb_dat_i on the last one, status 00, then RSP.
- RETRY:
  - cyc/stb=0 for exactly one cycle, then back to BUS.
  - Total bus attempts = MAX_RETRY+1.
- RSP:
  - rsp_valid_o=1; rsp_dat_o and rsp_status_o held stable.
  - On rsp_valid_o & rsp_ready_i, go to IDLE.
  - No new command is accepted until then.
- Latency against a combinational-ack responder:
  - Accept at edge N; cyc/stb high in cycle N+1; ack sampled at edge N+2.
  - Write: rsp_valid_o from N+2.
  - Read with delay 1: rsp_valid_o from N+3.
- rsp_dat_o is 0 for writes, ERR, RTY and TIMEOUT; it keeps the last captured value only for OK reads.
- Reset mid-operation: at the reset edge, cyc/stb drop immediately, any in-flight command is discarded, and no response is issued.

Optional Feature:
- Macro: COREPORT_WBM_TIMEOUT_EN.
- Defined:
  - A cycle counter runs while in BUS and restarts on every BUS entry, including retries.
  - After TIMEOUT_CYCLES consecutive BUS cycles with no ack/err/rty, drop cyc/stb, status 11, go to RSP.
  - A response arriving on the timeout edge takes precedence over the timeout.
- Undefined:
  - No counter; BUS waits indefinitely and status 11 is never produced.

Test Plan:
- GPIO-model responder (ack=stb, registered read data), RD_DATA_DELAY=1: write 0x14←0xA5, then read 0x14 -> both status 00; read rsp_dat_o=0xA5; write response 2 cycles after accept, read response 3.
- Back-to-back commands with rsp_ready_i held low for 5 cycles -> cmd_ready_o low throughout, rsp_valid_o/rsp_dat_o stable, no second bus cycle until consumed.
- Responder asserts err and ack together on a read -> status 01, rsp_dat_o=0, single bus attempt.
- MAX_RETRY=2, responder always rty -> exactly 3 stb pulses, each separated by 1 idle cycle, status 10. Responder rty twice then ack -> status 00.
- COREPORT_WBM_TIMEOUT_EN, TIMEOUT_CYCLES=16, silent responder -> cyc/stb high exactly 16 cycles, status 11. Without the macro, cyc stays high for 1000 cycles.
- Assert wb_rst during BUS of a write -> cyc/stb low after the reset edge, no rsp_valid_o, cmd_ready_o=1 after reset; the next command completes normally.
